std_seq_ctrl: RTL and testbench

//  Initiator side of the go/done latency-insensitive protocol spoken by std_reg-style primitives.

---
 rtl/std_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_std_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/std_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : std_seq_ctrl
// Description : Go/done sequencer. Starts NUM_STAGES child stages one at a
//               time, waits for each child's done, repeats the whole sequence
//               'iters' times and then pulses done to the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module std_seq_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int ITER_W     = 8,
    localparam int CUR_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [ITER_W-1:0]     iters,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_go,
    output logic                  done,
    output logic                  busy,
    output logic [CUR_W-1:0]      cur_stage,
    output logic [ITER_W-1:0]     iter_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CUR_W-1:0] C_LAST_STAGE = CUR_W'(NUM_STAGES - 1);

    state_t                  state_q,     state_d;
    logic [NUM_STAGES-1:0]   stage_go_q,  stage_go_d;
    logic                    done_q,      done_d;
    logic                    busy_q,      busy_d;
    logic [CUR_W-1:0]        cur_stage_q, cur_stage_d;
    logic [ITER_W-1:0]       iter_cnt_q,  iter_cnt_d;
    logic [ITER_W-1:0]       iters_q,     iters_d;

    // One wider than the counter so the "more iterations left" test cannot wrap.
    logic [ITER_W:0]         iter_next;
    assign iter_next = {1'b0, iter_cnt_q} + 1'b1;

    // Next-state and next-output logic; every output is produced here and then registered.
    always_comb begin
        state_d     = state_q;
        stage_go_d  = '0;
        done_d      = 1'b0;
        cur_stage_d = cur_stage_q;
        iter_cnt_d  = iter_cnt_q;
        iters_d     = iters_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    cur_stage_d = '0;
                    iter_cnt_d  = '0;
                    iters_d     = iters;
                    if (iters != '0) begin
                        state_d    = ST_RUN;
                        stage_go_d = NUM_STAGES'(1);
                    end else begin
                        // Zero iterations: complete immediately without touching any child.
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!go) begin
                    // Abort has priority over a done arriving in the same cycle.
                    state_d = ST_IDLE;
                end else if (stage_done[cur_stage_q]) begin
                    if (cur_stage_q != C_LAST_STAGE) begin
                        state_d     = ST_GAP;
                        cur_stage_d = cur_stage_q + 1'b1;
                    end else if (iter_next < {1'b0, iters_q}) begin
                        state_d     = ST_GAP;
                        cur_stage_d = '0;
                        iter_cnt_d  = iter_next[ITER_W-1:0];
                    end else begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        iter_cnt_d = iter_next[ITER_W-1:0];
                    end
                end else begin
                    stage_go_d = NUM_STAGES'(1) << cur_stage_q;
                end
            end
            ST_GAP: begin
                // One idle cycle so a child still holding done is not counted again.
                if (!go) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_RUN;
                    stage_go_d = NUM_STAGES'(1) << cur_stage_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            stage_go_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cur_stage_q <= '0;
            iter_cnt_q  <= '0;
            iters_q     <= '0;
        end else begin
            state_q     <= state_d;
            stage_go_q  <= stage_go_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cur_stage_q <= cur_stage_d;
            iter_cnt_q  <= iter_cnt_d;
            iters_q     <= iters_d;
        end
    end

    assign stage_go  = stage_go_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign cur_stage = cur_stage_q;
    assign iter_cnt  = iter_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_std_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_std_seq_ctrl
// Description : Self-checking bench for std_seq_ctrl. A two-stage and a
//               one-stage sequencer drive std_reg-style children; expected
//               outputs come from the cycle arithmetic of a run
//               (three cycles per stage: RUN, RUN, GAP/DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_std_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       go_drv;
    logic       sel;
    logic [7:0] iters_drv;
    logic [1:0] noise;

    int vectors    = 0;
    int miscompares = 0;

    // Two-stage instance
    logic       go_a;
    logic [1:0] child_a, sdone_a, sg_a;
    logic       done_a, busy_a;
    logic [0:0] cur_a;
    logic [7:0] icnt_a;

    // One-stage instance
    logic       go_b;
    logic [0:0] child_b, sg_b;
    logic       done_b, busy_b;
    logic [0:0] cur_b;
    logic [7:0] icnt_b;

    always #5 clk = ~clk;

    assign go_a    = go_drv & ~sel;
    assign go_b    = go_drv & sel;
    assign sdone_a = child_a | noise;

    std_seq_ctrl #(.NUM_STAGES(2), .ITER_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .go(go_a), .iters(iters_drv),
        .stage_done(sdone_a), .stage_go(sg_a), .done(done_a),
        .busy(busy_a), .cur_stage(cur_a), .iter_cnt(icnt_a)
    );

    std_seq_ctrl #(.NUM_STAGES(1), .ITER_W(8)) u_dut_b (
        .clk(clk), .reset(reset), .go(go_b), .iters(iters_drv),
        .stage_done(child_b), .stage_go(sg_b), .done(done_b),
        .busy(busy_b), .cur_stage(cur_b), .iter_cnt(icnt_b)
    );

    // std_reg-style children: done is the go line delayed by one cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            child_a <= '0;
            child_b <= '0;
        end else begin
            child_a <= sg_a;
            child_b <= sg_b;
        end
    end

    // Observed outputs of the selected instance, packed {stage_go, done, busy, cur, iter_cnt}.
    logic [12:0] obs_v;
    assign obs_v = sel ? {1'b0, sg_b, done_b, busy_b, cur_b, icnt_b}
                       : {sg_a, done_a, busy_a, cur_a, icnt_a};

    // One run of 'it' iterations over 'n' stages, started at the next edge.
    // Caller is just past a negedge. abort_at<0 means no abort.
    task automatic run_seq(input string tag, input bit s, input int n, input int it,
                           input int abort_at, input bit use_noise, input bit drop_go);
        int          total, slot, ph, st, itn;
        bit          fin;
        logic [1:0]  e_go;
        logic        e_done, e_cur;
        logic [7:0]  e_icnt;
        logic [12:0] exp_v;
        total     = 3 * n * it;
        sel       = s;
        iters_drv = 8'(it);
        go_drv    = 1'b1;
        noise     = '0;
        e_cur     = 1'b0;
        e_icnt    = '0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            slot = k / 3;
            ph   = k % 3;
            st   = slot % n;
            itn  = slot / n;
            fin  = (slot == n * it - 1);
            if (ph < 2) begin
                e_go   = 2'(1 << st);
                e_done = 1'b0;
                e_cur  = 1'(st);
                e_icnt = 8'(itn);
            end else begin
                e_go   = 2'b00;
                e_done = fin;
                e_cur  = fin ? 1'(st) : 1'((st + 1) % n);
                e_icnt = (st == n - 1) ? 8'(itn + 1) : 8'(itn);
            end
            exp_v = {e_go, e_done, 1'b1, e_cur, e_icnt};
            vectors++;
            if (obs_v !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got go/done/busy/cur/cnt=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                         tag, k, obs_v[12:11], obs_v[10], obs_v[9], obs_v[8], obs_v[7:0],
                         exp_v[12:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
            // Inputs for the next edge; iters must already be latched, so scramble it.
            iters_drv = 8'($urandom);
            noise     = '0;
            if (use_noise && n == 2) begin
                noise = 2'($urandom);
                if (ph < 2) noise[st] = 1'b0;
            end
            if (k + 1 == abort_at) begin
                go_drv = 1'b0;
                @(negedge clk);
                noise = '0;
                exp_v = {2'b00, 1'b0, 1'b0, e_cur, e_icnt};
                vectors++;
                if (obs_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL %s abort@%0d: got %h want %h", tag, abort_at, obs_v, exp_v);
                end
                return;
            end
        end
        noise = '0;
        if (drop_go) go_drv = 1'b0;
        @(negedge clk);
        exp_v = {2'b00, 1'b0, 1'b0, 1'(n - 1), 8'(it)};
        vectors++;
        if (obs_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s idle-after-done: got %h want %h", tag, obs_v, exp_v);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        go_drv    = 1'b0;
        sel       = 1'b0;
        iters_drv = 8'd3;
        noise     = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({sg_a, done_a, busy_a, cur_a, icnt_a, sg_b, done_b, busy_b, cur_b, icnt_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got a=%b%b%b%b%h b=%b%b%b%b%h want all zero",
                     sg_a, done_a, busy_a, cur_a, icnt_a, sg_b, done_b, busy_b, cur_b, icnt_b);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (obs_v !== '0) begin
            miscompares++;
            $display("FAIL idle_no_go: got %h want 0", obs_v);
        end
    endtask

    task automatic test_zero_iters();
        sel       = 1'b0;
        iters_drv = 8'd0;
        go_drv    = 1'b1;
        @(negedge clk);
        vectors++;
        if ({sg_a, done_a, busy_a} !== 4'b0011) begin
            miscompares++;
            $display("FAIL zero_iters_done: got go/done/busy=%b/%b/%b want 00/1/1", sg_a, done_a, busy_a);
        end
        go_drv = 1'b0;
        @(negedge clk);
        vectors++;
        if ({sg_a, done_a, busy_a} !== 4'b0000) begin
            miscompares++;
            $display("FAIL zero_iters_idle: got go/done/busy=%b/%b/%b want 00/0/0", sg_a, done_a, busy_a);
        end
    endtask

    task automatic test_reset_midrun();
        sel       = 1'b0;
        iters_drv = 8'd2;
        go_drv    = 1'b1;
        repeat (3) @(negedge clk);   // edges e0..e2: now in GAP
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({sg_a, done_a, busy_a, cur_a, icnt_a} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_mid_gap: got go/done/busy/cur/cnt=%b/%b/%b/%b/%0d want all zero",
                     sg_a, done_a, busy_a, cur_a, icnt_a);
        end
        @(negedge clk);
        reset = 1'b1;
        run_seq("fresh_after_reset", 1'b0, 2, 1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        bit s;
        int n, it, ab;
        for (int r = 0; r < 24; r++) begin
            s  = 1'($urandom % 2);
            n  = s ? 1 : 2;
            it = $urandom_range(1, 4);
            ab = ($urandom % 3 == 0) ? $urandom_range(1, 3 * n * it - 1) : -1;
            run_seq("random", s, n, it, ab, 1'b1, 1'b1);
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        run_seq("two_stage_one_iter", 1'b0, 2, 1, -1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        run_seq("single_stage_three_iter", 1'b1, 1, 3, -1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        test_zero_iters();
        repeat (2) @(negedge clk);
        run_seq("stray_done", 1'b0, 2, 2, -1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        run_seq("abort_stage1", 1'b0, 2, 1, 4, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        run_seq("back_to_back_1", 1'b0, 2, 2, -1, 1'b1, 1'b0);
        run_seq("back_to_back_2", 1'b0, 2, 1, -1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        test_reset_midrun();
        repeat (2) @(negedge clk);
        run_seq("max_iters", 1'b1, 1, 255, -1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
